// File: rtl/arc4_seq_ctrl_if.sv
// Bundle of the ARC4 sequencer's start/ready handshake, the three engine
// memory request ports and the muxed S memory port.
// slave  = the sequencer's view, master = the surrounding system's view.
interface arc4_seq_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              en;
  logic              rdy;
  logic [23:0]       key;
  logic [23:0]       key_q;
  logic              err;

  logic              init_en;
  logic              init_rdy;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_wrdata;
  logic              init_wren;

  logic              ksa_en;
  logic              ksa_rdy;
  logic [ADDR_W-1:0] ksa_addr;
  logic [DATA_W-1:0] ksa_wrdata;
  logic              ksa_wren;

  logic              prga_en;
  logic              prga_rdy;
  logic [ADDR_W-1:0] prga_addr;
  logic [DATA_W-1:0] prga_wrdata;
  logic              prga_wren;

  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wrdata;
  logic              s_wren;
  // Read data goes straight from the memory to every engine; the sequencer
  // never looks at it, so it is not part of the slave view.
  logic [DATA_W-1:0] s_rddata;

  modport slave (
    input  en, key,
    input  init_rdy, init_addr, init_wrdata, init_wren,
    input  ksa_rdy, ksa_addr, ksa_wrdata, ksa_wren,
    input  prga_rdy, prga_addr, prga_wrdata, prga_wren,
    output rdy, key_q, err, init_en, ksa_en, prga_en,
    output s_addr, s_wrdata, s_wren
  );

  modport master (
    output en, key,
    output init_rdy, init_addr, init_wrdata, init_wren,
    output ksa_rdy, ksa_addr, ksa_wrdata, ksa_wren,
    output prga_rdy, prga_addr, prga_wrdata, prga_wren,
    output s_rddata,
    input  rdy, key_q, err, init_en, ksa_en, prga_en,
    input  s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/arc4_seq_ctrl.sv
// ARC4 top-level sequencer: runs init -> ksa -> prga over the en/rdy
// handshake, gives the single-port S memory to whichever engine is active,
// latches the key at start and aborts a stalled engine with a watchdog.
module arc4_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int TMO_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  arc4_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, INIT_GO, INIT_BUSY, KSA_GO, KSA_BUSY, PRGA_GO, PRGA_BUSY
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE, OWN_INIT, OWN_KSA, OWN_PRGA
  } owner_t;

  state_t             state_q, state_d;
  owner_t             owner_q, owner_d;
  logic               busy_seen_q, busy_seen_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [23:0]        key_q, key_d;
  logic               err_q, err_d;

  logic               cur_rdy;
  logic               is_go;
  logic               is_busy;
  state_t             busy_state;
  state_t             next_go;
  owner_t             next_owner;
  logic               go_pulse;
  logic               tmo;

  assign tmo = &cnt_q;

  // Decode which engine the current state talks to and where it goes next.
  always_comb begin
    cur_rdy    = 1'b0;
    is_go      = 1'b0;
    is_busy    = 1'b0;
    busy_state = IDLE;
    next_go    = IDLE;
    next_owner = OWN_NONE;
    case (state_q)
      INIT_GO:   begin is_go = 1'b1;   cur_rdy = bus.init_rdy; busy_state = INIT_BUSY; end
      INIT_BUSY: begin is_busy = 1'b1; cur_rdy = bus.init_rdy; next_go = KSA_GO;  next_owner = OWN_KSA;  end
      KSA_GO:    begin is_go = 1'b1;   cur_rdy = bus.ksa_rdy;  busy_state = KSA_BUSY;  end
      KSA_BUSY:  begin is_busy = 1'b1; cur_rdy = bus.ksa_rdy;  next_go = PRGA_GO; next_owner = OWN_PRGA; end
      PRGA_GO:   begin is_go = 1'b1;   cur_rdy = bus.prga_rdy; busy_state = PRGA_BUSY; end
      PRGA_BUSY: begin is_busy = 1'b1; cur_rdy = bus.prga_rdy; next_go = IDLE;    next_owner = OWN_NONE; end
      default: ;
    endcase
  end

  // Next-state logic: start, engine completion, watchdog abort, GO -> BUSY.
  // Completion is tested before the watchdog so that an engine finishing on
  // the very cycle the counter saturates is not flagged as a timeout.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    busy_seen_d = busy_seen_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    err_d       = err_q;
    go_pulse    = 1'b0;

    if (state_q == IDLE) begin
      cnt_d = '0;
      if (bus.en) begin
        key_d   = bus.key;
        err_d   = 1'b0;
        owner_d = OWN_INIT;
        state_d = INIT_GO;
      end
    end else if (is_busy && busy_seen_q && cur_rdy) begin
      // Owner only changes together with GO entry, so the memory never sees
      // a write from an engine that is not the one being started.
      busy_seen_d = 1'b0;
      cnt_d       = '0;
      owner_d     = next_owner;
      state_d     = next_go;
    end else if (tmo) begin
      err_d       = 1'b1;
      owner_d     = OWN_NONE;
      busy_seen_d = 1'b0;
      cnt_d       = '0;
      state_d     = IDLE;
    end else begin
      cnt_d = cnt_q + TMO_W'(1);
      if (is_go && cur_rdy) begin
        go_pulse = 1'b1;
        state_d  = busy_state;
      end
      // The engine must be seen busy at least once before its rdy counts
      // as "finished"; this also guarantees two cycles in BUSY minimum.
      if (is_busy && !cur_rdy) begin
        busy_seen_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      busy_seen_q <= 1'b0;
      cnt_q       <= '0;
      key_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      busy_seen_q <= busy_seen_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      err_q       <= err_d;
    end
  end

  assign bus.rdy     = (state_q == IDLE);
  assign bus.key_q   = key_q;
  assign bus.err     = err_q;
  assign bus.init_en = go_pulse && (state_q == INIT_GO);
  assign bus.ksa_en  = go_pulse && (state_q == KSA_GO);
  assign bus.prga_en = go_pulse && (state_q == PRGA_GO);

  // S memory mux: only the registered owner reaches the memory port.
  always_comb begin
    bus.s_addr   = '0;
    bus.s_wrdata = '0;
    bus.s_wren   = 1'b0;
    case (owner_q)
      OWN_INIT: begin
        bus.s_addr   = bus.init_addr;
        bus.s_wrdata = bus.init_wrdata;
        bus.s_wren   = bus.init_wren;
      end
      OWN_KSA: begin
        bus.s_addr   = bus.ksa_addr;
        bus.s_wrdata = bus.ksa_wrdata;
        bus.s_wren   = bus.ksa_wren;
      end
      OWN_PRGA: begin
        bus.s_addr   = bus.prga_addr;
        bus.s_wrdata = bus.prga_wrdata;
        bus.s_wren   = bus.prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arc4_seq_ctrl.sv
// Bench for arc4_seq_ctrl. Instance A (16-bit watchdog) runs full
// init/ksa/prga sequences against stub engines with randomized busy times
// and memory traffic; instance B (6-bit watchdog) exercises the
// completion-vs-timeout boundary and a stalled ksa engine.
module tb_arc4_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arc4_seq_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
  arc4_seq_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

  arc4_seq_ctrl #(.ADDR_W(8), .DATA_W(8), .TMO_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  arc4_seq_ctrl #(.ADDR_W(8), .DATA_W(8), .TMO_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- stub engines, instance A ----------------
  // An engine drops rdy for len cycles after it is started, then rises.
  int unsigned len_a [3];
  int unsigned cnt_a [3];
  logic [2:0]  rdy_a;
  logic [2:0]  en_a;
  assign en_a = {bus_a.prga_en, bus_a.ksa_en, bus_a.init_en};
  assign bus_a.init_rdy = rdy_a[0];
  assign bus_a.ksa_rdy  = rdy_a[1];
  assign bus_a.prga_rdy = rdy_a[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_a <= 3'b111;
      for (int e = 0; e < 3; e++) cnt_a[e] <= 0;
    end else begin
      for (int e = 0; e < 3; e++) begin
        if (en_a[e] && rdy_a[e]) begin
          rdy_a[e] <= 1'b0;
          cnt_a[e] <= len_a[e] - 1;
        end else if (!rdy_a[e]) begin
          if (cnt_a[e] == 0) rdy_a[e] <= 1'b1;
          else cnt_a[e] <= cnt_a[e] - 1;
        end
      end
    end
  end

  // ---------------- stub engines, instance B ----------------
  // init busy 62 cycles; ksa never ready; prga always ready.
  int unsigned cnt_b;
  logic        rdy_b;
  assign bus_b.init_rdy = rdy_b;
  assign bus_b.ksa_rdy  = 1'b0;
  assign bus_b.prga_rdy = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_b <= 1'b1;
      cnt_b <= 0;
    end else if (bus_b.init_en && rdy_b) begin
      rdy_b <= 1'b0;
      cnt_b <= 61;
    end else if (!rdy_b) begin
      if (cnt_b == 0) rdy_b <= 1'b1;
      else cnt_b <= cnt_b - 1;
    end
  end

  logic [23:0] model_key_a = 24'h0;

  task automatic chk_reset_a(input string pfx);
    chk({pfx, "_rdy"},     bus_a.rdy,      1);
    chk({pfx, "_err"},     bus_a.err,      0);
    chk({pfx, "_key_q"},   bus_a.key_q,    0);
    chk({pfx, "_init_en"}, bus_a.init_en,  0);
    chk({pfx, "_ksa_en"},  bus_a.ksa_en,   0);
    chk({pfx, "_prga_en"}, bus_a.prga_en,  0);
    chk({pfx, "_s_addr"},  bus_a.s_addr,   0);
    chk({pfx, "_s_wrd"},   bus_a.s_wrdata, 0);
    chk({pfx, "_s_wren"},  bus_a.s_wren,   0);
  endtask

  // One full run on instance A. Expected timeline from the handshake rules:
  // en at cycle 0 -> init_en at 1; each engine with busy time L is started
  // L+2 cycles after the previous one; rdy returns L3+2 after prga_en.
  task automatic run_a(input int l1, input int l2, input int l3,
                       input logic [23:0] key_in, input int rst_at,
                       input int ignore_at);
    int kk, kp, kr, own;
    logic [7:0] ia, iw, ka, kw, pa, pw, ea, ew;
    logic iwe, kwe, pwe, ewe;
    len_a[0] = l1; len_a[1] = l2; len_a[2] = l3;
    kk = 1 + l1 + 2;
    kp = kk + l2 + 2;
    kr = kp + l3 + 2;
    for (int k = 0; k <= kr + 3; k++) begin
      @(negedge clk);
      ia = 8'($urandom); iw = 8'($urandom); iwe = 1'($urandom);
      ka = 8'($urandom); kw = 8'($urandom); kwe = 1'($urandom);
      pa = 8'($urandom); pw = 8'($urandom); pwe = 1'($urandom);
      if (k >= kk && k < kp) begin
        ia = 8'hAA; iwe = 1'b1; pa = 8'hAA; pwe = 1'b1;
      end
      bus_a.init_addr = ia; bus_a.init_wrdata = iw; bus_a.init_wren = iwe;
      bus_a.ksa_addr  = ka; bus_a.ksa_wrdata  = kw; bus_a.ksa_wren  = kwe;
      bus_a.prga_addr = pa; bus_a.prga_wrdata = pw; bus_a.prga_wren = pwe;
      if (k == 0) begin
        bus_a.en = 1'b1; bus_a.key = key_in;
      end else if (k == ignore_at) begin
        bus_a.en = 1'b1; bus_a.key = 24'hFFFFFF;
      end else begin
        bus_a.en  = (k < kr) && ($urandom_range(0, 7) == 0);
        bus_a.key = 24'($urandom);
      end
      if (k == rst_at) rst_n = 1'b0;
      #1;
      if (k == rst_at) begin
        chk_reset_a("midrst");
        model_key_a = 24'h0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.en = 1'b0;
        return;
      end
      own = (k >= 1 && k < kk) ? 1 : (k >= kk && k < kp) ? 2 : (k >= kp && k < kr) ? 3 : 0;
      case (own)
        1: begin ea = ia; ew = iw; ewe = iwe; end
        2: begin ea = ka; ew = kw; ewe = kwe; end
        3: begin ea = pa; ew = pw; ewe = pwe; end
        default: begin ea = 8'h0; ew = 8'h0; ewe = 1'b0; end
      endcase
      chk("a_s_addr",  bus_a.s_addr,   ea);
      chk("a_s_wrd",   bus_a.s_wrdata, ew);
      chk("a_s_wren",  bus_a.s_wren,   ewe);
      chk("a_init_en", bus_a.init_en,  k == 1);
      chk("a_ksa_en",  bus_a.ksa_en,   k == kk);
      chk("a_prga_en", bus_a.prga_en,  k == kp);
      chk("a_rdy",     bus_a.rdy,      (k == 0) || (k >= kr));
      chk("a_err",     bus_a.err,      0);
      chk("a_key_q",   bus_a.key_q,    (k >= 1) ? key_in : model_key_a);
    end
    model_key_a = key_in;
  endtask

  // Instance B: init finishes exactly when its 6-bit counter saturates
  // (completion must win), then ksa stalls in GO and times out 64 cycles
  // after KSA_GO entry.
  task automatic run_b(input logic err_prev);
    int kk;
    kk = 65;
    for (int k = 0; k <= kk + 66; k++) begin
      @(negedge clk);
      bus_b.en  = (k == 0);
      bus_b.key = 24'($urandom);
      #1;
      chk("b_rdy",     bus_b.rdy,     (k == 0) || (k >= kk + 64));
      chk("b_err",     bus_b.err,     (k == 0) ? err_prev : (k >= kk + 64));
      chk("b_init_en", bus_b.init_en, k == 1);
      chk("b_ksa_en",  bus_b.ksa_en,  0);
      chk("b_s_wren",  bus_b.s_wren,  (k >= kk) && (k < kk + 64));
      chk("b_s_addr",  bus_b.s_addr,
          (k >= 1 && k < kk) ? 8'h33 : (k >= kk && k < kk + 64) ? 8'h5A : 8'h00);
    end
  endtask

  initial begin
    bus_a.en = 1'b0; bus_a.key = '0; bus_a.s_rddata = '0;
    bus_a.init_addr = '0; bus_a.init_wrdata = '0; bus_a.init_wren = 1'b0;
    bus_a.ksa_addr  = '0; bus_a.ksa_wrdata  = '0; bus_a.ksa_wren  = 1'b0;
    bus_a.prga_addr = '0; bus_a.prga_wrdata = '0; bus_a.prga_wren = 1'b0;
    bus_b.en = 1'b0; bus_b.key = '0; bus_b.s_rddata = '0;
    bus_b.init_addr = 8'h33; bus_b.init_wrdata = 8'h01; bus_b.init_wren = 1'b0;
    bus_b.ksa_addr  = 8'h5A; bus_b.ksa_wrdata  = 8'h02; bus_b.ksa_wren  = 1'b1;
    bus_b.prga_addr = 8'h77; bus_b.prga_wrdata = 8'h03; bus_b.prga_wren = 1'b0;
    len_a[0] = 1; len_a[1] = 1; len_a[2] = 1;

    // reset held three cycles, then released with en low
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_a("inrst");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_a("postrst");
    chk("b_post_rdy",   bus_b.rdy,    1);
    chk("b_post_err",   bus_b.err,    0);
    chk("b_post_swren", bus_b.s_wren, 0);

    // long nominal run, with an ignored en/key pulse during INIT_BUSY
    run_a(256, 1536, 64, 24'h00033C, -1, 4);

    // short randomized runs
    for (int r = 0; r < 4; r++) begin
      run_a($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 40),
            24'($urandom), -1, -1);
    end

    // reset in the middle of PRGA_BUSY, then a clean run
    begin
      int l1, l2;
      l1 = $urandom_range(1, 20);
      l2 = $urandom_range(1, 20);
      run_a(l1, l2, 20, 24'($urandom), (1 + l1 + 2) + l2 + 2 + 5, -1);
    end
    run_a($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(1, 20),
          24'($urandom), -1, -1);

    // watchdog boundary and stalled engine, then restart clears err
    run_b(1'b0);
    run_b(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
